// File: rtl/timer_apb_regs.sv
// timer_apb_regs
// APB register and control block for one 8-bit timer counter. It decodes
// software accesses to the timer registers and drives the counter's control
// inputs. It also holds the clock prescaler and the interrupt logic.
//
// Optional feature macro: TIMER_IRQ_EN
//   When this macro is defined, the TIE register and the irq logic are built.
//   When it is not defined, TIE reads as 0x00, writes to TIE are ignored,
//   and irq is tied to 0.
//
// Ports
//   clk, rst                  : clock and synchronous active-high reset
//   psel/penable/pwrite       : APB control
//   paddr/pwdata [7:0]        : APB address and write data
//   prdata [7:0]              : read data, valid while pready is high
//   pready, pslverr           : transfer completion and error response
//   start_counter [7:0]       : TDR value presented to the counter
//   load                      : one-cycle load pulse (TCR.LOAD written as 1)
//   up_down, enable           : TCR.UP and TCR.EN
//   clk_ena                   : prescaled count strobe
//   clr_overflow/underflow    : one-cycle write-1-to-clear pulses
//   overflow, underflow       : counter flags
//   tcnt [7:0]                : live counter value
//   irq                       : registered level interrupt
//   dbg_state [1:0]           : APB FSM state (0 idle, 1 wait, 2 resp)
//
// Register map
//   0x00 TDR   RW
//   0x01 TCR   RW   [7] LOAD (write-only), [5] UP, [4] EN, [1:0] CKS
//   0x02 TSR   RO mirror of {UDF, OVF}; write 1 to clear
//   0x03 TCNT  RO; writes are ignored and give no error
//   0x04 TIE   RW   [1] UDIE, [0] OVIE
//   Any other address returns 0x00 with pslverr=1.
//
// Handshake: a transfer has exactly three cycles.
//   1. Setup: psel=1, penable=0. The FSM moves IDLE -> WAIT.
//   2. Wait: penable=1 and pready=0. The FSM moves WAIT -> RESP.
//      If psel drops here, the FSM returns to IDLE and nothing is committed.
//   3. Response: pready=1, with prdata and pslverr valid.
// A write is committed on the clock edge that ends the response cycle.
// The master holds the bus stable through the response cycle.
module timer_apb_regs #(
  parameter int PRESCALE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] start_counter,
  output logic       load,
  output logic       up_down,
  output logic       enable,
  output logic       clk_ena,
  output logic       clr_overflow,
  output logic       clr_underflow,
  input  logic       overflow,
  input  logic       underflow,
  input  logic [7:0] tcnt,
  output logic       irq,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;
  localparam logic [7:0] ADDR_TIE  = 8'h04;
  // Only UP, EN and CKS are stored. LOAD is a pulse and is never stored.
  localparam logic [7:0] TCR_MASK  = 8'h33;

  state_e                state_q, state_d;
  logic [7:0]            prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [7:0]            tdr_q, tdr_d;
  logic [7:0]            tcr_q, tcr_d;
  logic                  load_q, load_d;
  logic                  clr_ovf_q, clr_ovf_d;
  logic                  clr_udf_q, clr_udf_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  clk_ena_q, clk_ena_d;
  logic                  irq_q, irq_d;
`ifdef TIMER_IRQ_EN
  logic [7:0]            tie_q, tie_d;
`endif

  logic                  addr_ok;
  logic                  wr_commit;
  logic                  tcr_wr;
  logic [7:0]            rdata;
  logic [PRESCALE_W-1:0] cks_mask;

  // Address decode and read mux.
  always_comb begin
    addr_ok   = (paddr <= ADDR_TIE);
    wr_commit = (state_q == ST_RESP) && psel && pwrite && addr_ok;
    tcr_wr    = wr_commit && (paddr == ADDR_TCR);
    rdata     = 8'h00;
    case (paddr)
      ADDR_TDR:  rdata = tdr_q;
      ADDR_TCR:  rdata = tcr_q;
      ADDR_TSR:  rdata = {6'b0, underflow, overflow};
      ADDR_TCNT: rdata = tcnt;
      ADDR_TIE: begin
`ifdef TIMER_IRQ_EN
        rdata = tie_q;
`else
        rdata = 8'h00;
`endif
      end
      default:   rdata = 8'h00;
    endcase
  end

  // CKS=n selects the low n+1 prescaler bits, which gives division by 2^(n+1).
  always_comb begin
    cks_mask = '0;
    for (int i = 0; i < PRESCALE_W; i++) begin
      cks_mask[i] = (i <= int'(tcr_q[1:0]));
    end
  end

  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    prdata_d  = 8'h00;
    pslverr_d = 1'b0;
    tdr_d     = tdr_q;
    tcr_d     = tcr_q;
    load_d    = 1'b0;
    clr_ovf_d = 1'b0;
    clr_udf_d = 1'b0;
`ifdef TIMER_IRQ_EN
    tie_d     = tie_q;
`endif

    case (state_q)
      ST_IDLE: if (psel && !penable) state_d = ST_WAIT;
      ST_WAIT: begin
        if (psel) begin
          // Register the response so that it appears together with pready.
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          prdata_d  = rdata;
          pslverr_d = !addr_ok;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (wr_commit) begin
      case (paddr)
        ADDR_TDR: tdr_d = pwdata;
        ADDR_TCR: begin
          tcr_d  = pwdata & TCR_MASK;
          load_d = pwdata[7];
        end
        ADDR_TSR: begin
          clr_ovf_d = pwdata[0];
          clr_udf_d = pwdata[1];
        end
`ifdef TIMER_IRQ_EN
        ADDR_TIE: tie_d = pwdata & 8'h03;
`endif
        default: ;
      endcase
    end

    // The prescaler runs only while EN=1. Any TCR write restarts its phase.
    // The strobe is suppressed on the write edge, so a new setting takes
    // effect immediately.
    if (!tcr_q[4] || tcr_wr) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
    clk_ena_d = tcr_q[4] && !tcr_wr && ((presc_q & cks_mask) == cks_mask);

`ifdef TIMER_IRQ_EN
    irq_d = (overflow & tie_q[0]) | (underflow & tie_q[1]);
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prdata_q  <= 8'h00;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tdr_q     <= 8'h00;
      tcr_q     <= 8'h00;
      load_q    <= 1'b0;
      clr_ovf_q <= 1'b0;
      clr_udf_q <= 1'b0;
      presc_q   <= '0;
      clk_ena_q <= 1'b0;
      irq_q     <= 1'b0;
`ifdef TIMER_IRQ_EN
      tie_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      tdr_q     <= tdr_d;
      tcr_q     <= tcr_d;
      load_q    <= load_d;
      clr_ovf_q <= clr_ovf_d;
      clr_udf_q <= clr_udf_d;
      presc_q   <= presc_d;
      clk_ena_q <= clk_ena_d;
      irq_q     <= irq_d;
`ifdef TIMER_IRQ_EN
      tie_q     <= tie_d;
`endif
    end
  end

  assign prdata        = prdata_q;
  assign pready        = pready_q;
  assign pslverr       = pslverr_q;
  assign start_counter = tdr_q;
  assign load          = load_q;
  assign up_down       = tcr_q[5];
  assign enable        = tcr_q[4];
  assign clk_ena       = clk_ena_q;
  assign clr_overflow  = clr_ovf_q;
  assign clr_underflow = clr_udf_q;
  assign irq           = irq_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed testbench for timer_apb_regs.
module tb_timer_apb_regs;

`ifdef TIMER_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic       clk, rst;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic [7:0] start_counter;
  logic       load, up_down, enable, clk_ena;
  logic       clr_overflow, clr_underflow;
  logic       overflow, underflow;
  logic [7:0] tcnt;
  logic       irq;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  timer_apb_regs #(.PRESCALE_W(4)) dut (
    .clk(clk), .rst(rst),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .start_counter(start_counter), .load(load), .up_down(up_down),
    .enable(enable), .clk_ena(clk_ena),
    .clr_overflow(clr_overflow), .clr_underflow(clr_underflow),
    .overflow(overflow), .underflow(underflow), .tcnt(tcnt),
    .irq(irq), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checkers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drivers
  // Runs setup, wait and response. It returns #1 after the response cycle
  // begins, with the bus still held, so the next call can start back-to-back.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    chk1("pready_setup", pready, 1'b0);
    @(posedge clk); #1;
    penable = 1'b1;
    chk1("pready_wait", pready, 1'b0);
    @(posedge clk); #1;
    chk1("pready_resp", pready, 1'b1);
    rdata = prdata;
    err   = pslverr;
  endtask

  // Passes through the commit edge and releases the bus.
  // It returns #1 into the cycle after the commit.
  task automatic bus_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Samples clk_ena over three periods. It checks the cycle offset of the
  // first strobe and the spacing between the first two strobes.
  task automatic measure_clk_ena(input int first_exp, input int period, input string tag);
    int first, second;
    first  = -1;
    second = -1;
    for (int k = 0; k < 3 * period; k++) begin
      if (clk_ena === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      @(posedge clk); #1;
    end
    chk32({tag, "_first"}, first, first_exp);
    chk32({tag, "_period"}, second - first, period);
  endtask

  logic [7:0] rd;
  logic       er;
  int         cnt;

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    overflow = 1'b0; underflow = 1'b0; tcnt = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Reset values, sampled while rst is still high
    chk8("rst_prdata", prdata, 8'h00);
    chk1("rst_pready", pready, 1'b0);
    chk1("rst_pslverr", pslverr, 1'b0);
    chk8("rst_start_counter", start_counter, 8'h00);
    chk1("rst_load", load, 1'b0);
    chk1("rst_up_down", up_down, 1'b0);
    chk1("rst_enable", enable, 1'b0);
    chk1("rst_clk_ena", clk_ena, 1'b0);
    chk1("rst_clr_ovf", clr_overflow, 1'b0);
    chk1("rst_clr_udf", clr_underflow, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    chk8("rst_state", {6'b0, dbg_state}, 8'h00);
    rst = 1'b0;

    // Reads after reset, issued back-to-back
    apb_xfer(1'b0, 8'h00, 8'h00, rd, er); chk8("rd_tdr_rst", rd, 8'h00); chk1("err_tdr_rst", er, 1'b0);
    apb_xfer(1'b0, 8'h01, 8'h00, rd, er); chk8("rd_tcr_rst", rd, 8'h00);
    apb_xfer(1'b0, 8'h02, 8'h00, rd, er); chk8("rd_tsr_rst", rd, 8'h00);
    apb_xfer(1'b0, 8'h04, 8'h00, rd, er); chk8("rd_tie_rst", rd, 8'h00); chk1("err_tie_rst", er, 1'b0);
    bus_idle();

    // TDR=0xFE, then TCR=0x90 (LOAD+EN, CKS=0)
    apb_xfer(1'b1, 8'h00, 8'hFE, rd, er); bus_idle();
    chk8("start_counter_fe", start_counter, 8'hFE);
    apb_xfer(1'b1, 8'h01, 8'h90, rd, er); bus_idle();
    chk1("load_pulse", load, 1'b1);
    chk1("enable_on", enable, 1'b1);
    chk1("up_down_0", up_down, 1'b0);
    chk1("clk_ena_at_en", clk_ena, 1'b0);
    @(posedge clk); #1;
    chk1("load_single", load, 1'b0);
    measure_clk_ena(1, 2, "cks0");
    tcnt = 8'hFF;
    apb_xfer(1'b0, 8'h03, 8'h00, rd, er); chk8("rd_tcnt_ff", rd, 8'hFF);
    apb_xfer(1'b0, 8'h01, 8'h00, rd, er); chk8("rd_tcr_10", rd, 8'h10);
    bus_idle();

    // TCR=0x33 (UP+EN, CKS=3), then TCR=0x00
    apb_xfer(1'b1, 8'h01, 8'h33, rd, er); bus_idle();
    chk1("up_down_1", up_down, 1'b1);
    chk1("load_none", load, 1'b0);
    measure_clk_ena(16, 16, "cks3");
    apb_xfer(1'b0, 8'h01, 8'h00, rd, er); chk8("rd_tcr_33", rd, 8'h33);
    bus_idle();
    apb_xfer(1'b1, 8'h01, 8'h00, rd, er); bus_idle();
    chk1("enable_off", enable, 1'b0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (clk_ena === 1'b1) cnt++;
      @(posedge clk); #1;
    end
    chk32("clk_ena_stopped", cnt, 0);

    // Interrupt and flag clears
    apb_xfer(1'b1, 8'h04, 8'h01, rd, er);
    apb_xfer(1'b0, 8'h04, 8'h00, rd, er); chk8("rd_tie_01", rd, IRQ_EN ? 8'h01 : 8'h00);
    bus_idle();
    overflow = 1'b1;
    apb_xfer(1'b0, 8'h02, 8'h00, rd, er); chk8("rd_tsr_ovf", rd, 8'h01);
    bus_idle();
    chk1("irq_ovf", irq, IRQ_EN);
    apb_xfer(1'b1, 8'h02, 8'h01, rd, er); bus_idle();
    chk1("clr_ovf_pulse", clr_overflow, 1'b1);
    chk1("clr_udf_quiet", clr_underflow, 1'b0);
    @(posedge clk); #1;
    chk1("clr_ovf_single", clr_overflow, 1'b0);
    apb_xfer(1'b1, 8'h02, 8'h02, rd, er); bus_idle();
    chk1("clr_udf_pulse", clr_underflow, 1'b1);
    chk1("clr_ovf_quiet", clr_overflow, 1'b0);
    @(posedge clk); #1;
    chk1("clr_udf_single", clr_underflow, 1'b0);
    overflow = 1'b0;
    @(posedge clk); #1;
    chk1("irq_cleared", irq, 1'b0);
    underflow = 1'b1;
    apb_xfer(1'b0, 8'h02, 8'h00, rd, er); chk8("rd_tsr_udf", rd, 8'h02);
    bus_idle();
    underflow = 1'b0;

    // Unmapped address and read-only TCNT
    apb_xfer(1'b0, 8'h07, 8'h00, rd, er); chk8("rd_bad_data", rd, 8'h00); chk1("rd_bad_err", er, 1'b1);
    apb_xfer(1'b1, 8'h07, 8'hFF, rd, er); chk1("wr_bad_err", er, 1'b1);
    apb_xfer(1'b0, 8'h00, 8'h00, rd, er); chk8("tdr_kept", rd, 8'hFE); chk1("tdr_err0", er, 1'b0);
    apb_xfer(1'b0, 8'h01, 8'h00, rd, er); chk8("tcr_kept", rd, 8'h00);
    apb_xfer(1'b0, 8'h04, 8'h00, rd, er); chk8("tie_kept", rd, IRQ_EN ? 8'h01 : 8'h00);
    tcnt = 8'h3C;
    apb_xfer(1'b1, 8'h03, 8'h55, rd, er); chk1("wr_tcnt_err", er, 1'b0);
    apb_xfer(1'b0, 8'h03, 8'h00, rd, er); chk8("rd_tcnt_3c", rd, 8'h3C);
    bus_idle();

    // Back-to-back write then read
    apb_xfer(1'b1, 8'h00, 8'h12, rd, er);
    apb_xfer(1'b0, 8'h00, 8'h00, rd, er); chk8("b2b_rd_tdr", rd, 8'h12);
    bus_idle();

    // Reset during the wait cycle of a TDR=0xAA write
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hAA;
    @(posedge clk); #1;
    penable = 1'b1;
    chk8("state_wait", {6'b0, dbg_state}, 8'h01);
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("rstmid_pready", pready, 1'b0);
    chk8("rstmid_state", {6'b0, dbg_state}, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("rstmid_pready2", pready, 1'b0);
    chk8("rstmid_state2", {6'b0, dbg_state}, 8'h00);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk8("rstmid_tdr", start_counter, 8'h00);
    apb_xfer(1'b0, 8'h00, 8'h00, rd, er); chk8("rstmid_rd_tdr", rd, 8'h00); chk1("rstmid_err", er, 1'b0);
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
